// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue stage: opnum encodings, opcode
// fields, operand bundle and common constants.
package issue_ctrl_pkg;

    localparam int ROB_W   = 4;
    localparam int OPNUM_W = 6;

    localparam logic       TRUE     = 1'b1;
    localparam logic       FALSE    = 1'b0;
    localparam logic [4:0] ZERO_REG = 5'd0;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    typedef enum logic [OPNUM_W-1:0] {
        OP_NULL, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } opnum_e;

    localparam opnum_e OPNUM_NULL = OP_NULL;

    typedef struct packed {
        logic [31:0]      v;
        logic [ROB_W-1:0] q;
        logic             qv;
    } opnd_t;

endpackage

// File: rtl/issue_ctrl_dec.sv
// RV32I instruction decoder: opnum, register fields, immediate and
// the operand-usage / class flags the issue stage needs.
module issue_ctrl_dec
    import issue_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output opnum_e      opnum,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic        use1,
    output logic        use2,
    output logic        is_ls,
    output logic        is_jump,
    output logic        wr_rd
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    assign rd  = inst[11:7];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};

    always_comb begin
        opnum   = OP_NULL;
        imm     = '0;
        use1    = FALSE;
        use2    = FALSE;
        is_ls   = FALSE;
        is_jump = FALSE;
        wr_rd   = FALSE;
        unique case (opc)
            OPC_LUI: begin
                opnum = OP_LUI;
                imm   = imm_u;
                wr_rd = TRUE;
            end
            OPC_AUIPC: begin
                opnum = OP_AUIPC;
                imm   = imm_u;
                wr_rd = TRUE;
            end
            OPC_JAL: begin
                opnum   = OP_JAL;
                imm     = imm_j;
                is_jump = TRUE;
                wr_rd   = TRUE;
            end
            OPC_JALR: begin
                if (f3 == 3'b000) opnum = OP_JALR;
                imm     = imm_i;
                use1    = TRUE;
                is_jump = TRUE;
                wr_rd   = TRUE;
            end
            OPC_BR: begin
                case (f3)
                    3'b000:  opnum = OP_BEQ;
                    3'b001:  opnum = OP_BNE;
                    3'b100:  opnum = OP_BLT;
                    3'b101:  opnum = OP_BGE;
                    3'b110:  opnum = OP_BLTU;
                    3'b111:  opnum = OP_BGEU;
                    default: opnum = OP_NULL;
                endcase
                imm     = imm_b;
                use1    = TRUE;
                use2    = TRUE;
                is_jump = TRUE;
            end
            OPC_LOAD: begin
                case (f3)
                    3'b000:  opnum = OP_LB;
                    3'b001:  opnum = OP_LH;
                    3'b010:  opnum = OP_LW;
                    3'b100:  opnum = OP_LBU;
                    3'b101:  opnum = OP_LHU;
                    default: opnum = OP_NULL;
                endcase
                imm   = imm_i;
                use1  = TRUE;
                is_ls = TRUE;
                wr_rd = TRUE;
            end
            OPC_STORE: begin
                case (f3)
                    3'b000:  opnum = OP_SB;
                    3'b001:  opnum = OP_SH;
                    3'b010:  opnum = OP_SW;
                    default: opnum = OP_NULL;
                endcase
                imm   = imm_s;
                use1  = TRUE;
                use2  = TRUE;
                is_ls = TRUE;
            end
            OPC_OPIMM: begin
                imm   = imm_i;
                use1  = TRUE;
                wr_rd = TRUE;
                case (f3)
                    3'b000: opnum = OP_ADDI;
                    3'b010: opnum = OP_SLTI;
                    3'b011: opnum = OP_SLTIU;
                    3'b100: opnum = OP_XORI;
                    3'b110: opnum = OP_ORI;
                    3'b111: opnum = OP_ANDI;
                    3'b001: begin
                        imm = {27'b0, inst[24:20]};
                        if (f7 == 7'b0000000) opnum = OP_SLLI;
                    end
                    default: begin
                        imm = {27'b0, inst[24:20]};
                        if (f7 == 7'b0000000) opnum = OP_SRLI;
                        else if (f7 == 7'b0100000) opnum = OP_SRAI;
                    end
                endcase
            end
            OPC_OP: begin
                use1  = TRUE;
                use2  = TRUE;
                wr_rd = TRUE;
                if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
                    case ({f7[5], f3})
                        4'b0000: opnum = OP_ADD;
                        4'b1000: opnum = OP_SUB;
                        4'b0001: opnum = OP_SLL;
                        4'b0010: opnum = OP_SLT;
                        4'b0011: opnum = OP_SLTU;
                        4'b0100: opnum = OP_XOR;
                        4'b0101: opnum = OP_SRL;
                        4'b1101: opnum = OP_SRA;
                        4'b0110: opnum = OP_OR;
                        4'b0111: opnum = OP_AND;
                        default: opnum = OP_NULL;
                    endcase
                end
            end
            default: opnum = OP_NULL;
        endcase
    end

endmodule

// File: rtl/issue_ctrl.sv
// Issue stage: latches the queue head, renames its operands and
// dispatches a registered packet to ROB plus RS or LSB.
module issue_ctrl
    import issue_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rollback,
    input  logic               iq_valid,
    input  logic [31:0]        iq_inst,
    input  logic [31:0]        iq_pc,
    input  logic               iq_pred_jump,
    output logic               iq_pop,
    input  logic               rob_full,
    input  logic               rs_full,
    input  logic               lsb_full,
    input  logic [ROB_W-1:0]   rob_free_tag,
    output logic [4:0]         rf_rs1,
    output logic [4:0]         rf_rs2,
    input  logic               rf_busy1,
    input  logic               rf_busy2,
    input  logic [ROB_W-1:0]   rf_tag1,
    input  logic [ROB_W-1:0]   rf_tag2,
    input  logic [31:0]        rf_val1,
    input  logic [31:0]        rf_val2,
    output logic [ROB_W-1:0]   rob_q1_tag,
    output logic [ROB_W-1:0]   rob_q2_tag,
    input  logic               rob_q1_ready,
    input  logic               rob_q2_ready,
    input  logic [31:0]        rob_q1_val,
    input  logic [31:0]        rob_q2_val,
    input  logic               cdb_valid,
    input  logic [ROB_W-1:0]   cdb_tag,
    input  logic [31:0]        cdb_val,
    output logic               rob_alloc,
    output logic               rs_dispatch,
    output logic               lsb_dispatch,
    output logic [OPNUM_W-1:0] d_opnum,
    output logic [4:0]         d_rd,
    output logic [ROB_W-1:0]   d_tag,
    output logic [31:0]        d_pc,
    output logic [31:0]        d_imm,
    output logic               d_pred_jump,
    output logic               d_is_jump,
    output logic [31:0]        d_v1,
    output logic [31:0]        d_v2,
    output logic [ROB_W-1:0]   d_q1,
    output logic [ROB_W-1:0]   d_q2,
    output logic               d_q1_valid,
    output logic               d_q2_valid,
    output logic               rf_rename_en,
    output logic [4:0]         rf_rename_rd,
    output logic [ROB_W-1:0]   rf_rename_tag
);

    typedef enum logic {ST_EMPTY, ST_HELD} st_e;

    st_e         state, state_n;
    logic [31:0] inst_q, inst_n;
    logic [31:0] pc_q, pc_n;
    logic        pred_q, pred_n;

    logic        alloc_q, rs_q, lsb_q, ren_q;

    opnum_e      dec_op;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [31:0] dec_imm;
    logic        dec_use1, dec_use2, dec_ls, dec_jump, dec_wr;

    logic        held, live, go, drop;
    opnd_t       op1, op2;

    issue_ctrl_dec u_dec (
        .inst    (inst_q),
        .opnum   (dec_op),
        .rd      (dec_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .imm     (dec_imm),
        .use1    (dec_use1),
        .use2    (dec_use2),
        .is_ls   (dec_ls),
        .is_jump (dec_jump),
        .wr_rd   (dec_wr)
    );

    function automatic opnd_t resolve(
        input logic             used,
        input logic [4:0]       idx,
        input logic             busy,
        input logic [ROB_W-1:0] tag,
        input logic [31:0]      rval,
        input logic             rob_rdy,
        input logic [31:0]      rob_val,
        input logic             cv,
        input logic [ROB_W-1:0] ct,
        input logic [31:0]      cval
    );
        opnd_t r;
        r = '0;
        if (!used || idx == ZERO_REG) r = '0;
        else if (!busy) r.v = rval;
        else if (rob_rdy) r.v = rob_val;
        else if (cv && ct == tag) r.v = cval;
        else begin
            r.q  = tag;
            r.qv = TRUE;
        end
        return r;
    endfunction

    assign rf_rs1     = dec_rs1;
    assign rf_rs2     = dec_rs2;
    assign rob_q1_tag = rf_tag1;
    assign rob_q2_tag = rf_tag2;

    // Strobe registers freeze with rdy low; the outputs are masked meanwhile.
    assign rob_alloc    = alloc_q & rdy;
    assign rs_dispatch  = rs_q & rdy;
    assign lsb_dispatch = lsb_q & rdy;
    assign rf_rename_en = ren_q & rdy;

    always_comb begin
        held = (state == ST_HELD);
        live = rdy & ~rollback & ~rst;
        drop = held & (dec_op == OPNUM_NULL);
        go   = held & (dec_op != OPNUM_NULL) & ~rob_full
             & (dec_ls ? ~lsb_full : ~rs_full);
        iq_pop = live & iq_valid & (~held | go | drop);

        op1 = resolve(dec_use1, dec_rs1, rf_busy1, rf_tag1, rf_val1,
                      rob_q1_ready, rob_q1_val,
                      cdb_valid, cdb_tag, cdb_val);
        op2 = resolve(dec_use2, dec_rs2, rf_busy2, rf_tag2, rf_val2,
                      rob_q2_ready, rob_q2_val,
                      cdb_valid, cdb_tag, cdb_val);

        state_n = state;
        inst_n  = inst_q;
        pc_n    = pc_q;
        pred_n  = pred_q;
        if (iq_pop) begin
            state_n = ST_HELD;
            inst_n  = iq_inst;
            pc_n    = iq_pc;
            pred_n  = iq_pred_jump;
        end else if (go | drop) begin
            state_n = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (rdy && rollback)) begin
            state         <= ST_EMPTY;
            inst_q        <= '0;
            pc_q          <= '0;
            pred_q        <= 1'b0;
            alloc_q       <= 1'b0;
            rs_q          <= 1'b0;
            lsb_q         <= 1'b0;
            ren_q         <= 1'b0;
            d_opnum       <= '0;
            d_rd          <= '0;
            d_tag         <= '0;
            d_pc          <= '0;
            d_imm         <= '0;
            d_pred_jump   <= 1'b0;
            d_is_jump     <= 1'b0;
            d_v1          <= '0;
            d_v2          <= '0;
            d_q1          <= '0;
            d_q2          <= '0;
            d_q1_valid    <= 1'b0;
            d_q2_valid    <= 1'b0;
            rf_rename_rd  <= '0;
            rf_rename_tag <= '0;
        end else if (rdy) begin
            state   <= state_n;
            inst_q  <= inst_n;
            pc_q    <= pc_n;
            pred_q  <= pred_n;
            alloc_q <= go;
            rs_q    <= go & ~dec_ls;
            lsb_q   <= go & dec_ls;
            ren_q   <= go & dec_wr & (dec_rd != ZERO_REG);
            if (go) begin
                d_opnum       <= dec_op;
                d_rd          <= dec_rd;
                d_tag         <= rob_free_tag;
                d_pc          <= pc_q;
                d_imm         <= dec_imm;
                d_pred_jump   <= pred_q;
                d_is_jump     <= dec_jump;
                d_v1          <= op1.v;
                d_v2          <= op2.v;
                d_q1          <= op1.q;
                d_q2          <= op2.q;
                d_q1_valid    <= op1.qv;
                d_q2_valid    <= op2.qv;
                rf_rename_rd  <= dec_rd;
                rf_rename_tag <= rob_free_tag;
            end
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: dispatch, stalls, operand
// resolution, rollback, rdy freeze and illegal-instruction drop.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               rst, rdy, rollback;
    logic               iq_valid, iq_pred_jump, iq_pop;
    logic [31:0]        iq_inst, iq_pc;
    logic               rob_full, rs_full, lsb_full;
    logic [ROB_W-1:0]   rob_free_tag;
    logic [4:0]         rf_rs1, rf_rs2;
    logic               rf_busy1, rf_busy2;
    logic [ROB_W-1:0]   rf_tag1, rf_tag2;
    logic [31:0]        rf_val1, rf_val2;
    logic [ROB_W-1:0]   rob_q1_tag, rob_q2_tag;
    logic               rob_q1_ready, rob_q2_ready;
    logic [31:0]        rob_q1_val, rob_q2_val;
    logic               cdb_valid;
    logic [ROB_W-1:0]   cdb_tag;
    logic [31:0]        cdb_val;
    logic               rob_alloc, rs_dispatch, lsb_dispatch;
    logic [OPNUM_W-1:0] d_opnum;
    logic [4:0]         d_rd;
    logic [ROB_W-1:0]   d_tag;
    logic [31:0]        d_pc, d_imm;
    logic               d_pred_jump, d_is_jump;
    logic [31:0]        d_v1, d_v2;
    logic [ROB_W-1:0]   d_q1, d_q2;
    logic               d_q1_valid, d_q2_valid;
    logic               rf_rename_en;
    logic [4:0]         rf_rename_rd;
    logic [ROB_W-1:0]   rf_rename_tag;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] I_ADDI1 = 32'h00500093;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_ADDI5 = 32'h00700293;
    localparam logic [31:0] I_ADD   = 32'h00208333;
    localparam logic [31:0] I_SW    = 32'h00312223;
    localparam logic [31:0] I_BEQ   = 32'h00208463;

    issue_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
        .iq_pred_jump(iq_pred_jump), .iq_pop(iq_pop),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_free_tag(rob_free_tag),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_busy1(rf_busy1), .rf_busy2(rf_busy2),
        .rf_tag1(rf_tag1), .rf_tag2(rf_tag2),
        .rf_val1(rf_val1), .rf_val2(rf_val2),
        .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag),
        .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
        .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .rob_alloc(rob_alloc), .rs_dispatch(rs_dispatch),
        .lsb_dispatch(lsb_dispatch),
        .d_opnum(d_opnum), .d_rd(d_rd), .d_tag(d_tag), .d_pc(d_pc),
        .d_imm(d_imm), .d_pred_jump(d_pred_jump), .d_is_jump(d_is_jump),
        .d_v1(d_v1), .d_v2(d_v2), .d_q1(d_q1), .d_q2(d_q2),
        .d_q1_valid(d_q1_valid), .d_q2_valid(d_q2_valid),
        .rf_rename_en(rf_rename_en), .rf_rename_rd(rf_rename_rd),
        .rf_rename_tag(rf_rename_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; rdy = 1; rollback = 0;
        iq_valid = 0; iq_inst = '0; iq_pc = '0; iq_pred_jump = 0;
        rob_full = 0; rs_full = 0; lsb_full = 0; rob_free_tag = '0;
        rf_busy1 = 0; rf_busy2 = 0; rf_tag1 = '0; rf_tag2 = '0;
        rf_val1 = '0; rf_val2 = '0;
        rob_q1_ready = 0; rob_q2_ready = 0;
        rob_q1_val = '0; rob_q2_val = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_val = '0;
        tick;
        tick;
        chk("rst_alloc", 32'(rob_alloc), 0);
        chk("rst_rs", 32'(rs_dispatch), 0);
        chk("rst_lsb", 32'(lsb_dispatch), 0);
        chk("rst_opnum", 32'(d_opnum), 0);
        chk("rst_tag", 32'(d_tag), 0);
        chk("rst_ren", 32'(rf_rename_en), 0);

        // addi x1,x0,5
        rst = 0; rob_free_tag = 4'd3; rf_val1 = 32'h99;
        iq_valid = 1; iq_inst = I_ADDI1; iq_pc = 32'h100;
        #1 chk("addi_pop", 32'(iq_pop), 1);
        tick;
        iq_valid = 0;
        #1 chk("addi_nopop", 32'(iq_pop), 0);
        tick;
        chk("addi_rs", 32'(rs_dispatch), 1);
        chk("addi_lsb", 32'(lsb_dispatch), 0);
        chk("addi_alloc", 32'(rob_alloc), 1);
        chk("addi_opnum", 32'(d_opnum), 32'(OP_ADDI));
        chk("addi_imm", d_imm, 5);
        chk("addi_v1", d_v1, 0);
        chk("addi_q1v", 32'(d_q1_valid), 0);
        chk("addi_tag", 32'(d_tag), 3);
        chk("addi_pc", d_pc, 32'h100);
        chk("addi_ren", 32'(rf_rename_en), 1);
        chk("addi_renrd", 32'(rf_rename_rd), 1);
        chk("addi_rentag", 32'(rf_rename_tag), 3);

        // lw x2,0(x1) stalled by lsb_full
        lsb_full = 1; rf_val1 = 32'h40;
        iq_valid = 1; iq_inst = I_LW; iq_pc = 32'h104;
        #1 chk("lw_pop", 32'(iq_pop), 1);
        tick;
        chk("lw_idle_alloc", 32'(rob_alloc), 0);
        chk("lw_idle_rs", 32'(rs_dispatch), 0);
        iq_inst = I_ADDI5; iq_pc = 32'h108;
        #1 chk("lw_stall_pop", 32'(iq_pop), 0);
        chk("lw_rs1", 32'(rf_rs1), 1);
        tick;
        chk("lw_stall_lsb", 32'(lsb_dispatch), 0);
        chk("lw_stall_alloc", 32'(rob_alloc), 0);
        chk("lw_stall_pop2", 32'(iq_pop), 0);
        lsb_full = 0; rob_free_tag = 4'd6;
        #1 chk("lw_go_pop", 32'(iq_pop), 1);
        tick;
        chk("lw_lsb", 32'(lsb_dispatch), 1);
        chk("lw_rs", 32'(rs_dispatch), 0);
        chk("lw_alloc", 32'(rob_alloc), 1);
        chk("lw_tag", 32'(d_tag), 6);
        chk("lw_v1", d_v1, 32'h40);
        chk("lw_opnum", 32'(d_opnum), 32'(OP_LW));
        chk("lw_renrd", 32'(rf_rename_rd), 2);
        iq_valid = 0; rob_free_tag = 4'd7;
        tick;
        chk("b2b_rs", 32'(rs_dispatch), 1);
        chk("b2b_rd", 32'(d_rd), 5);
        chk("b2b_imm", d_imm, 7);
        chk("b2b_tag", 32'(d_tag), 7);
        chk("b2b_rentag", 32'(rf_rename_tag), 7);

        // add x6,x1,x2 with rs1 resolved off the CDB
        iq_valid = 1; iq_inst = I_ADD; iq_pc = 32'h200;
        tick;
        iq_valid = 0;
        rf_busy1 = 1; rf_tag1 = 4'd5; rob_q1_ready = 0;
        cdb_valid = 1; cdb_tag = 4'd5; cdb_val = 32'h1234;
        rf_busy2 = 0; rf_val2 = 32'h22; rob_free_tag = 4'd8;
        #1 chk("cdb_robq1", 32'(rob_q1_tag), 5);
        tick;
        chk("cdb_rs", 32'(rs_dispatch), 1);
        chk("cdb_v1", d_v1, 32'h1234);
        chk("cdb_q1v", 32'(d_q1_valid), 0);
        chk("cdb_v2", d_v2, 32'h22);
        chk("cdb_q2v", 32'(d_q2_valid), 0);
        chk("cdb_pc", d_pc, 32'h200);

        // same add, no CDB: rs1 pending, rs2 from ROB
        iq_valid = 1; cdb_valid = 0;
        rf_busy2 = 1; rf_tag2 = 4'd7; rob_q2_ready = 1; rob_q2_val = 32'h77;
        tick;
        iq_valid = 0;
        tick;
        chk("pend_q1", 32'(d_q1), 5);
        chk("pend_q1v", 32'(d_q1_valid), 1);
        chk("pend_v1", d_v1, 0);
        chk("rob_v2", d_v2, 32'h77);
        chk("rob_q2v", 32'(d_q2_valid), 0);
        rf_busy1 = 0; rf_busy2 = 0; rob_q2_ready = 0;

        // rollback during an rs_full stall
        rs_full = 1;
        iq_valid = 1; iq_inst = I_ADDI5; iq_pc = 32'h300;
        tick;
        #1 chk("rb_stall_pop", 32'(iq_pop), 0);
        rollback = 1;
        #1 chk("rb_pop", 32'(iq_pop), 0);
        tick;
        chk("rb_rs", 32'(rs_dispatch), 0);
        chk("rb_alloc", 32'(rob_alloc), 0);
        chk("rb_opnum", 32'(d_opnum), 0);
        chk("rb_pc", d_pc, 0);
        chk("rb_ren", 32'(rf_rename_en), 0);
        rollback = 0;
        #1 chk("rb_empty_pop", 32'(iq_pop), 1);
        rs_full = 0;
        tick;

        // rdy low for 3 cycles while HELD and dispatchable
        iq_inst = I_SW; iq_pc = 32'h304; rdy = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("frz_pop", 32'(iq_pop), 0);
            tick;
            chk("frz_rs", 32'(rs_dispatch), 0);
            chk("frz_alloc", 32'(rob_alloc), 0);
        end
        rdy = 1; rob_free_tag = 4'd9;
        #1 chk("thaw_pop", 32'(iq_pop), 1);
        tick;
        chk("thaw_rs", 32'(rs_dispatch), 1);
        chk("thaw_rd", 32'(d_rd), 5);
        chk("thaw_tag", 32'(d_tag), 9);

        // sw x3,4(x2) then beq x1,x2,8 predicted taken
        iq_inst = I_BEQ; iq_pc = 32'h308; iq_pred_jump = 1;
        rob_free_tag = 4'd10;
        #1 chk("sw_pop", 32'(iq_pop), 1);
        tick;
        chk("sw_lsb", 32'(lsb_dispatch), 1);
        chk("sw_alloc", 32'(rob_alloc), 1);
        chk("sw_ren", 32'(rf_rename_en), 0);
        chk("sw_imm", d_imm, 4);
        chk("sw_opnum", 32'(d_opnum), 32'(OP_SW));
        iq_valid = 0; iq_pred_jump = 0;
        tick;
        chk("beq_rs", 32'(rs_dispatch), 1);
        chk("beq_jump", 32'(d_is_jump), 1);
        chk("beq_imm", d_imm, 8);
        chk("beq_pred", 32'(d_pred_jump), 1);
        chk("beq_ren", 32'(rf_rename_en), 0);
        chk("beq_opnum", 32'(d_opnum), 32'(OP_BEQ));

        // illegal instruction dropped, next one dispatched
        iq_valid = 1; iq_inst = 32'h0; iq_pc = 32'h400;
        #1 chk("ill_pop", 32'(iq_pop), 1);
        tick;
        iq_inst = I_ADDI5; iq_pc = 32'h404;
        #1 chk("ill_drop_pop", 32'(iq_pop), 1);
        tick;
        chk("ill_alloc", 32'(rob_alloc), 0);
        chk("ill_rs", 32'(rs_dispatch), 0);
        chk("ill_lsb", 32'(lsb_dispatch), 0);
        iq_valid = 0; rob_free_tag = 4'd11;
        tick;
        chk("post_rs", 32'(rs_dispatch), 1);
        chk("post_tag", 32'(d_tag), 11);
        chk("post_rd", 32'(d_rd), 5);
        chk("post_pc", d_pc, 32'h404);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
